// File: rtl/mem_bus_pkg.sv
// Shared FSM state type and default widths for the memory-port arbiter
// and its grant-selection helper.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

  localparam int DEFAULT_AW = 32;
  localparam int DEFAULT_DW = 32;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: fixed priority (highest index wins) or
// round-robin starting just after the last completed channel.
module rr_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int RR_MODE = 0,
  localparam int GW     = idx_width(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [GW-1:0]  ptr,
  output logic [GW-1:0]  grant,
  output logic           valid
);

  assign valid = |req;

  if (RR_MODE != 0) begin : g_rr
    // rot_req[k] is the channel k+1 positions after the pointer.
    logic [NCH-1:0] rot_req;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_rot
      assign rot_req[gi] = req[GW'((int'(ptr) + 1 + gi) % NCH)];
    end

    always_comb begin
      grant = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
        if (rot_req[k]) grant = GW'((int'(ptr) + 1 + k) % NCH);
      end
    end
  end else begin : g_fixed
    logic ptr_unused;
    assign ptr_unused = ^ptr;

    always_comb begin
      grant = '0;
      for (int i = 0; i < NCH; i++) begin
        if (req[i]) grant = GW'(i);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Multiplexes NCH SRAM-style requestor channels onto one sram-like bus,
// keeping at most one bus transaction outstanding.
module mem_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int AW      = DEFAULT_AW,
  parameter int DW      = DEFAULT_DW,
  parameter int RR_MODE = 0,
  localparam int SW     = DW / 8,
  localparam int GW     = idx_width(NCH)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NCH-1:0]      ch_en,
  input  logic [NCH*SW-1:0]   ch_wen,
  input  logic [NCH*AW-1:0]   ch_addr,
  input  logic [NCH*DW-1:0]   ch_wdata,
  output logic [DW-1:0]       ch_rdata,
  output logic [NCH-1:0]      ch_stall,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [SW-1:0]       bus_wstrb,
  output logic [AW-1:0]       bus_addr,
  output logic [DW-1:0]       bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DW-1:0]       bus_rdata
);

  arb_state_t    state_reg, state_next;
  logic [GW-1:0] grant_reg, ptr_reg, arb_grant;
  logic          arb_valid;
  logic          rdata_load;
  logic [AW-1:0] addr_reg;
  logic [SW-1:0] wstrb_reg;
  logic [DW-1:0] wdata_reg, rdata_reg;

  rr_arbiter #(
    .NCH     (NCH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req   (ch_en),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    bus_req    = 1'b0;
    rdata_load = 1'b0;
    case (state_reg)
      ST_IDLE: if (arb_valid) state_next = ST_REQ;
      ST_REQ: begin
        bus_req = 1'b1;
        if (bus_addr_ok) begin
          // Address and data accepted together skip the WAIT state.
          state_next = bus_data_ok ? ST_DONE : ST_WAIT;
          rdata_load = bus_data_ok;
        end
      end
      ST_WAIT: begin
        if (bus_data_ok) begin
          state_next = ST_DONE;
          rdata_load = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The request is captured once in IDLE; later ch_* changes never reach the bus.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_reg <= '0;
      ptr_reg   <= GW'(NCH - 1);
      addr_reg  <= '0;
      wstrb_reg <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      if (state_reg == ST_IDLE && arb_valid) begin
        grant_reg <= arb_grant;
        addr_reg  <= ch_addr[int'(arb_grant) * AW +: AW];
        wstrb_reg <= ch_wen[int'(arb_grant) * SW +: SW];
        wdata_reg <= ch_wdata[int'(arb_grant) * DW +: DW];
      end
      if (rdata_load) rdata_reg <= bus_rdata;
      if (state_reg == ST_DONE) ptr_reg <= grant_reg;
    end
  end

  assign bus_addr  = addr_reg;
  assign bus_wstrb = wstrb_reg;
  assign bus_wdata = wdata_reg;
  assign bus_wr    = |wstrb_reg;
  assign ch_rdata  = rdata_reg;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_stall
    assign ch_stall[gi] = ch_en[gi] & ~(state_reg == ST_DONE && grant_reg == GW'(gi));
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 2-channel fixed-priority instance with a
// scripted bus responder and a 4-channel round-robin instance on an always-ready bus.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  // Instance A: NCH=2, fixed priority
  logic [1:0]  a_en;
  logic [7:0]  a_wen;
  logic [63:0] a_addr, a_wdata;
  logic [31:0] a_rdata, a_baddr, a_bwdata, a_brdata;
  logic [1:0]  a_stall;
  logic        a_req, a_wr, a_aok, a_dok;
  logic [3:0]  a_wstrb;

  // Instance B: NCH=4, round-robin
  logic [3:0]   b_en;
  logic [15:0]  b_wen;
  logic [127:0] b_addr, b_wdata;
  logic [31:0]  b_rdata, b_baddr, b_bwdata, b_brdata;
  logic [3:0]   b_stall;
  logic         b_req, b_wr;
  logic [3:0]   b_wstrb;

  function automatic logic [31:0] rd_of(input logic [31:0] addr);
    return addr ^ 32'h83DD_BFC0;
  endfunction

  mem_port_arbiter #(.NCH(2), .AW(32), .DW(32), .RR_MODE(0)) dut_a (
    .clk(clk), .resetn(resetn), .ch_en(a_en), .ch_wen(a_wen), .ch_addr(a_addr),
    .ch_wdata(a_wdata), .ch_rdata(a_rdata), .ch_stall(a_stall), .bus_req(a_req),
    .bus_wr(a_wr), .bus_wstrb(a_wstrb), .bus_addr(a_baddr), .bus_wdata(a_bwdata),
    .bus_addr_ok(a_aok), .bus_data_ok(a_dok), .bus_rdata(a_brdata)
  );

  assign b_brdata = rd_of(b_baddr);

  mem_port_arbiter #(.NCH(4), .AW(32), .DW(32), .RR_MODE(1)) dut_b (
    .clk(clk), .resetn(resetn), .ch_en(b_en), .ch_wen(b_wen), .ch_addr(b_addr),
    .ch_wdata(b_wdata), .ch_rdata(b_rdata), .ch_stall(b_stall), .bus_req(b_req),
    .bus_wr(b_wr), .bus_wstrb(b_wstrb), .bus_addr(b_baddr), .bus_wdata(b_bwdata),
    .bus_addr_ok(1'b1), .bus_data_ok(1'b1), .bus_rdata(b_brdata)
  );

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  en;
    logic [7:0]  wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          ad;
    int          dd;
    bit          noise;
    bit          scramble;
    int          first;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  vec_t vec[7];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int a_dly, d_dly, ph, cnt;
  bit noise, b_hold, bus_chk;
  logic [31:0] lat_addr;
  logic [1:0]  a_done;
  logic [3:0]  b_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Bus responder for A: addr_ok after a_dly REQ cycles, data_ok d_dly cycles later.
  task automatic respond();
    a_aok = 1'b0;
    a_dok = 1'b0;
    if (!resetn) begin
      ph = 0; cnt = 0;
    end else if (ph == 0 && a_req) begin
      if (cnt == a_dly) begin
        a_aok = 1'b1;
        cnt = 0;
        if (d_dly == 0) begin
          a_dok = 1'b1;
          a_brdata = rd_of(a_baddr);
        end else begin
          ph = 1;
          lat_addr = a_baddr;
        end
      end else cnt++;
    end else if (ph == 1) begin
      a_aok = noise;
      cnt++;
      if (cnt == d_dly) begin
        a_dok = 1'b1;
        a_brdata = rd_of(lat_addr);
        ph = 0; cnt = 0;
      end
    end else begin
      a_dok = noise;
      a_brdata = $urandom;
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (qa.size() == 0) check("a_req_idle", a_req, 0);
    else if (bus_chk && a_req) begin
      check("a_bus_addr", a_baddr, qa[0].addr);
      check("a_bus_wr", a_wr, |qa[0].wstrb);
      check("a_bus_wstrb", a_wstrb, qa[0].wstrb);
      check("a_bus_wdata", a_bwdata, qa[0].wdata);
    end
    for (int i = 0; i < 2; i++) begin
      if (a_en[i] && !a_stall[i]) begin
        a_done[i] = 1'b1;
        if (qa.size() == 0) check("a_spurious_done", i, 99);
        else begin
          e = qa.pop_front();
          $display("[%0d] A done ch%0d rdata=%h", cyc, i, a_rdata);
          check("a_done_ch", i, e.ch);
          if (e.cyc >= 0) check("a_done_cyc", cyc, e.cyc);
          if (e.wstrb == 4'h0) check("a_rdata", a_rdata, e.rdata);
        end
      end
    end
    if (qb.size() == 0) check("b_req_idle", b_req, 0);
    else if (b_req) begin
      check("b_bus_addr", b_baddr, qb[0].addr);
      check("b_bus_wr", {b_wr, b_wstrb, b_bwdata}, 0);
    end
    for (int i = 0; i < 4; i++) begin
      if (b_en[i] && !b_stall[i]) begin
        b_done[i] = 1'b1;
        if (qb.size() == 0) check("b_spurious_done", i, 99);
        else begin
          e = qb.pop_front();
          $display("[%0d] B done ch%0d rdata=%h", cyc, i, b_rdata);
          check("b_done_ch", i, e.ch);
          check("b_done_cyc", cyc, e.cyc);
          check("b_rdata", b_rdata, e.rdata);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    a_en = a_en & ~a_done;
    if (!b_hold) b_en = b_en & ~b_done;
    a_done = '0;
    b_done = '0;
    respond();
    @(negedge clk);
    monitor();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < limit) begin
      step();
      n++;
    end
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
    qa.delete();
    qb.delete();
  endtask

  task automatic push_a(input int ch, input int c);
    exp_t e;
    e.ch    = ch;
    e.addr  = a_addr[ch*32 +: 32];
    e.wstrb = a_wen[ch*4 +: 4];
    e.wdata = a_wdata[ch*32 +: 32];
    e.rdata = rd_of(e.addr);
    e.cyc   = c;
    qa.push_back(e);
  endtask

  task automatic push_b(input int ch, input int c);
    exp_t e;
    e.ch    = ch;
    e.addr  = b_addr[ch*32 +: 32];
    e.wstrb = 4'h0;
    e.wdata = 32'h0;
    e.rdata = rd_of(e.addr);
    e.cyc   = c;
    qb.push_back(e);
  endtask

  initial begin
    int lat, c0;
    int rr_order[5];
    int rr_sparse[3];

    //        en     wen    addr {ch1,ch0}                   wdata {ch1,ch0}            ad dd nz sc first
    vec[0] = '{2'b01, 8'h00, {32'h0, 32'hBFC0_0000},        64'h0,                      0, 3, 0, 0, 0};
    vec[1] = '{2'b10, 8'h30, {32'h8000_1000, 32'h0},        {32'h1234_5678, 32'h0},     2, 1, 0, 0, 1};
    vec[2] = '{2'b11, 8'h00, {32'hA000_1004, 32'hA000_2008}, 64'h0,                     0, 0, 0, 0, 1};
    vec[3] = '{2'b11, 8'h0F, {32'h0000_4440, 32'h0000_5550}, {32'h0, 32'hCAFE_F00D},    1, 2, 1, 0, 1};
    vec[4] = '{2'b01, 8'h00, {32'h0, 32'h1FC0_0010},        64'h0,                      0, 0, 0, 1, 0};
    vec[5] = '{2'b10, 8'h00, {32'h7000_0020, 32'h0},        64'h0,                      3, 0, 1, 1, 1};
    vec[6] = '{2'b10, 8'hC0, {32'h6000_0030, 32'h0},        {32'hDEAD_BEEF, 32'h0},     0, 4, 1, 0, 1};
    rr_order  = '{0, 1, 2, 3, 0};
    rr_sparse = '{1, 3, 1};

    resetn = 1'b0;
    a_en = 2'b11; a_wen = '0; a_addr = '0; a_wdata = '0;
    b_en = 4'hF; b_wen = '0; b_wdata = '0;
    for (int i = 0; i < 4; i++) b_addr[i*32 +: 32] = 32'h1000_0000 + 32'(i * 'h40);
    a_aok = 1'b0; a_dok = 1'b0; a_brdata = '0;
    a_dly = 0; d_dly = 0; ph = 0; cnt = 0; noise = 1'b0; b_hold = 1'b0; bus_chk = 1'b1;
    lat_addr = '0; a_done = '0; b_done = '0;

    // Reset: stall follows ch_en, no bus request, rdata cleared
    step();
    check("rst_req_a", a_req, 0);
    check("rst_stall_a", a_stall, 2'b11);
    check("rst_rdata_a", a_rdata, 0);
    check("rst_stall_b", b_stall, 4'hF);
    step();
    check("rst_hold_stall_a", a_stall, 2'b11);
    check("rst_hold_req_b", b_req, 0);
    a_en = '0; b_en = '0;
    step();
    resetn = 1'b1;
    step();

    for (int v = 0; v < 7; v++) begin
      a_dly = vec[v].ad; d_dly = vec[v].dd; noise = vec[v].noise;
      a_wen = vec[v].wen; a_addr = vec[v].addr; a_wdata = vec[v].wdata;
      lat = 2 + vec[v].ad + vec[v].dd;
      push_a(vec[v].first, cyc + lat);
      if (vec[v].en == 2'b11) push_a(1 - vec[v].first, cyc + 2 * lat + 1);
      a_en = vec[v].en;
      if (vec[v].scramble) begin
        step();
        a_addr = {$urandom, $urandom};
        a_wdata = {$urandom, $urandom};
        a_wen = 8'($urandom);
      end
      drain(60);
      step(); step();
    end
    noise = 1'b0;

    // Reset pulled during WAIT abandons the transaction
    a_dly = 0; d_dly = 5; a_wen = '0; a_addr = {32'h0, 32'h0000_0100};
    push_a(0, -1);
    a_en = 2'b01;
    step(); step();
    check("wait_req_low", a_req, 0);
    resetn = 1'b0;
    #1;
    check("rst_wait_req", a_req, 0);
    check("rst_wait_stall", a_stall, 2'b01);
    check("rst_wait_rdata", a_rdata, 0);
    qa.delete();
    step();
    check("rst_wait_hold", a_stall, 2'b01);
    a_en = '0;
    step();
    resetn = 1'b1;
    step();
    d_dly = 0; a_addr = {32'h0, 32'h0000_0200};
    push_a(0, cyc + 2);
    a_en = 2'b01;
    drain(20);
    step(); step();

    // ch1 flushed during WAIT: its data is absorbed, ch0 follows
    a_dly = 0; d_dly = 3; bus_chk = 1'b0;
    a_addr = {32'h0000_0300, 32'h0000_0400};
    push_a(0, cyc + 11);
    a_en = 2'b11;
    step(); step();
    a_en[1] = 1'b0;
    drain(40);
    bus_chk = 1'b1;
    step(); step();

    // Round-robin, all four channels held: 0,1,2,3,0
    b_hold = 1'b1;
    c0 = cyc;
    for (int j = 0; j < 5; j++) push_b(rr_order[j], c0 + 2 + 3 * j);
    b_en = 4'hF;
    drain(60);
    b_en = '0;
    step(); step();

    // Sparse requests after the pointer settled on 0: 1,3,1
    c0 = cyc;
    for (int j = 0; j < 3; j++) push_b(rr_sparse[j], c0 + 2 + 3 * j);
    b_en = 4'b1010;
    drain(40);
    b_en = '0;
    b_hold = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NCH, default 2, number of SRAM-style requestor channels (1..8); channel 0 = inst, channel 1 = data.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width (multiple of 8); SW = DW/8.
REQ-004 Parameter RR_MODE, default 0: 0 = fixed priority, highest index wins; 1 = round-robin.
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port resetn, input, 1: reset, asynchronous and active-low.
REQ-007 Ports ch_en, input, NCH: per-channel access request, held stable while that channel's stall is high.
REQ-008 Ports ch_wen, input, NCH*SW: per-channel byte write strobes; all zero = read.
REQ-009 Ports ch_addr, input, NCH*AW: per-channel physical address.
REQ-010 Ports ch_wdata, input, NCH*DW: per-channel write data.
REQ-011 Ports ch_rdata, output, DW: read data, shared by all channels, valid only in the completing channel's done cycle.
REQ-012 Ports ch_stall, output, NCH: per-channel stall to the pipeline.
REQ-013 Ports bus_req, output, 1; bus_wr, output, 1; bus_wstrb, output, SW; bus_addr, output, AW; bus_wdata, output, DW: request side of the sram-like bus.
REQ-014 Ports bus_addr_ok, input, 1; bus_data_ok, input, 1; bus_rdata, input, DW: response side of the sram-like bus.

Function
REQ-015 FSM states: IDLE, REQ, WAIT, DONE; at most one bus transaction outstanding.
REQ-016 IDLE: if any ch_en is high, latch grant index g, address, strobes and wdata of g, then go to REQ; otherwise stay in IDLE.
REQ-017 REQ: bus_req=1 with the latched fields; bus_wr = |wstrb; on bus_addr_ok go to WAIT; if bus_addr_ok and bus_data_ok are both high, go directly to DONE.
REQ-018 WAIT: bus_req=0; on bus_data_ok register bus_rdata and go to DONE.
REQ-019 DONE: ch_rdata = registered data and ch_stall[g]=0 for exactly this one cycle; next state IDLE.
REQ-020 ch_stall[i] = ch_en[i] & ~(state==DONE & g==i), combinational.
REQ-021 Fixed mode: grant goes to the highest-index active channel.
REQ-022 Round-robin mode: grant goes to the first active channel after the last completed index, wrapping NCH-1 to 0; the pointer updates in DONE only; the pointer resets to NCH-1.
REQ-023 Writes also wait for bus_data_ok; ch_rdata is don't-care for writes.
REQ-024 Minimum latency: ch_en high in cycle 0 gives stall low in cycle 2 (addr_ok and data_ok both high in cycle 1).
REQ-025 If ch_en[g] drops while the transaction is in flight (flush), the bus transaction completes normally and the result is discarded; no other channel is served until DONE.
REQ-026 bus_data_ok in IDLE or DONE is ignored; bus_addr_ok outside REQ is ignored.
REQ-027 The latched request is not re-sampled after IDLE; changes on the ch_* inputs mid-transaction do not affect the bus.

Reset
REQ-028 resetn low asynchronously forces: state IDLE, bus_req 0, grant 0, RR pointer NCH-1, rdata register 0.
REQ-029 During reset, ch_stall equals ch_en; an in-flight bus transaction is abandoned, and the memory side is reset by the same resetn.

Structure
REQ-030 Shared package mem_bus_pkg holds the FSM state typedef and the default AW/DW constants.
REQ-031 Grant selection lives in one sub-module rr_arbiter (NCH, RR_MODE), combinational from the request vector and pointer.

Verification
REQ-032 NCH=2, fixed: ch_en=2'b11 in the same cycle -> ch1 served first (stall[1] low in cycle 2), then ch0; ch_stall[0] stays high until its own DONE.
REQ-033 Read ch0 addr 0xBFC00000, bus returns addr_ok at cycle 1 and data_ok at cycle 4 with rdata 0x3C1DBFC0 -> DONE at cycle 5, ch_rdata=0x3C1DBFC0, stall[0] low for exactly one cycle.
REQ-034 Write ch1 wen=4'b0011, wdata 0x12345678 -> bus_wr=1, bus_wstrb=4'b0011, bus_wdata=0x12345678, held until addr_ok.
REQ-035 RR_MODE=1, NCH=4, all ch_en held high -> completion order 0,1,2,3,0.
REQ-036 resetn pulled low during WAIT -> bus_req=0 and state IDLE immediately; after release, a fresh request completes normally.
REQ-037 ch_en[1] dropped during WAIT -> data_ok is absorbed, FSM returns to IDLE, no spurious stall release on ch1, and ch0 is served next.
